mem_channel_arbiter: RTL and testbench
======================================

Name: mem_channel_arbiter

Overview:
- Shares one single-lane off-chip memory port between the two master channels (lane 0, lane 1) of an HLS-generated accelerator. These channels are Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram and Mout_data_ram_size, with return paths M_Rdata_ram and M_DataRdy.
- Sits between the accelerator's packed master bus and a memory model or controller with a variable response latency.
- Arbitrates round-robin, registers the winning command, waits for the memory's ready pulse and routes the read data back to the owning lane.
- Flags protocol errors and memory timeouts.

Parameters:
- ADDR_W, 7: address bits per lane.
- DATA_W, 8: data bits per lane.
- SIZE_W, 4: access-size bits per lane.
- TIMEOUT, 64: maximum BUSY cycles before the transaction is aborted. Legal range 2..65535.

Ports:
- clock, in, 1: sole clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- m_oe, in, 2: per-lane read request. Held by the requester until it sees its m_datardy bit.
- m_we, in, 2: per-lane write request. Same hold rule as m_oe.
- m_addr, in, 2*ADDR_W: packed lane addresses; lane i occupies [i*ADDR_W +: ADDR_W].
- m_wdata, in, 2*DATA_W: packed lane write data.
- m_size, in, 2*SIZE_W: packed lane access sizes.
- m_rdata, out, 2*DATA_W: per-lane read data. Valid only while that lane's m_datardy bit is high.
- m_datardy, out, 2: per-lane completion, one-cycle pulse.
- s_oe, out, 1: memory read strobe.
- s_we, out, 1: memory write strobe.
- s_addr, out, ADDR_W: memory address.
- s_wdata, out, DATA_W: memory write data.
- s_size, out, SIZE_W: memory access size.
- s_rdata, in, DATA_W: memory read data. Sampled when s_datardy is high.
- s_datardy, in, 1: memory completion.
- clear_err, in, 1: synchronous clear of err_proto, err_timeout and err_lane.
- err_proto, out, 1: sticky; a lane asserted oe and we together.
- err_timeout, out, 1: sticky; the memory did not answer within TIMEOUT cycles.
- err_lane, out, 1: lane of the most recent error.

Behaviour:
- Reset (asynchronous assert, synchronous deassert):
  - State goes to IDLE and last_owner to 1, so lane 0 has first priority.
  - The BUSY counter is cleared.
  - All outputs are 0.
  - An in-flight transaction is abandoned. No m_datardy is issued for it.
- Lane validity: lane i is valid when exactly one of m_oe[i] and m_we[i] is high. A lane with both high is never granted. It sets err_proto and err_lane=i every cycle it persists.
- State IDLE:
  - If no lane is valid, stay in IDLE.
  - If one lane is valid, grant it.
  - If both are valid, grant the lane that is not last_owner.
  - On grant, register owner, op, addr, wdata and size, clear the counter, and go to BUSY.
- State BUSY:
  - s_oe/s_we, s_addr, s_wdata and s_size are driven from the registered command. They are stable for the whole state.
  - The counter increments each cycle.
  - If s_datardy=1: set m_rdata lane[owner] to s_rdata (registered; for writes it is s_rdata as presented), pulse m_datardy[owner] on the next cycle, drop s_oe/s_we, set last_owner=owner, and go to RELEASE.
  - Else if the counter reaches TIMEOUT-1: pulse m_datardy[owner] with m_rdata lane = 0, set err_timeout and err_lane=owner, drop the strobes, set last_owner=owner, and go to RELEASE.
  - A s_datardy arriving in the same cycle as the timeout wins: normal completion, no error.
- State RELEASE: lasts one cycle with strobes low, then goes to IDLE. The owner drops its request during this cycle, so a stale request is never re-granted.
- Non-owner lane: its m_rdata lane and m_datardy bit stay 0. Its request is held and not lost.
- Latency: a request first seen in IDLE at cycle t gives s_oe/s_we at t+1. s_datardy at cycle u gives m_datardy at u+1. The minimum lane turnaround is 4 cycles.
- s_datardy while not in BUSY is ignored.
- Errors:
  - err_proto and err_timeout are sticky until a clear_err cycle.
  - If clear_err and a new error occur in the same cycle, the set wins.
  - Errors do not stall arbitration.
- s_oe and s_we are never high together.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum: IDLE, BUSY, RELEASE;
  - the lane constants LANE0 and LANE1;
  - the op encoding: RD=0, WR=1;
  - the lane slice helper functions.
- Sub-module rr_pick2: combinational valid[1:0] plus last_owner giving grant and grant_lane. It is reused by the sibling multi-port arbiters.
- The top level holds the FSM, command register, timeout counter and error flags.

Test Plan:
1. Single read: lane 0 reads addr 0x05, the memory answers s_datardy two cycles after s_oe with s_rdata=0xA5 → s_oe=1 and s_addr=0x05 at t+1, m_datardy=2'b01 and m_rdata[7:0]=0xA5 at t+4, lane 1 outputs stay 0.
2. Contention: both lanes read from reset (0x01, 0x02) → lane 0 is served first, lane 1 second. With both held continuously over 6 transactions the grants strictly alternate 0,1,0,1,0,1.
3. Write: lane 1 writes 0x3C to 0x10 with size 8 → s_we=1, s_addr=0x10, s_wdata=0x3C, s_size=8 held until a write-delay-1 ready, then m_datardy=2'b10. s_oe stays 0 throughout.
4. Timeout: TIMEOUT=8 and the memory never answers → m_datardy[0] pulses at cycle 9 after the grant with rdata 0, err_timeout=1 and err_lane=0. A later clear_err clears them.
5. Protocol error: lane 1 drives oe=we=1 while lane 0 reads → err_proto=1, err_lane=1, lane 0 is served normally and lane 1 is never granted.
6. Reset mid-BUSY: reset asserted two cycles into a read → all outputs 0 immediately. After release, a fresh request is granted and no stale m_datardy pulse appears.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-channel arbiters.
//   state_e   : arbiter FSM states (IDLE, BUSY, RELEASE)
//   op_e      : registered command kind (RD=0, WR=1)
//   LANE0/1   : lane identifiers
//   lane_lsb  : bit offset of a lane inside a packed two-lane bus
//   lane_valid: a lane is requesting legally when exactly one strobe is high
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } op_e;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  function automatic int unsigned lane_lsb(input logic lane, input int unsigned width);
    return lane ? width : 32'd0;
  endfunction

  function automatic logic lane_valid(input logic oe, input logic we);
    return oe ^ we;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker (combinational).
//   valid      : per-lane legal request
//   last_owner : lane served most recently
//   grant      : at least one lane is valid
//   grant_lane : winning lane; on contention the lane that is not last_owner
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_owner,
  output logic       grant,
  output logic       grant_lane
);

  always_comb begin
    grant      = |valid;
    grant_lane = LANE0;
    case (valid)
      2'b01:   grant_lane = LANE0;
      2'b10:   grant_lane = LANE1;
      2'b11:   grant_lane = ~last_owner;
      default: grant_lane = LANE0;
    endcase
  end

endmodule

// File: rtl/mem_channel_arbiter.sv
// Shares one memory port between two accelerator master lanes.
//   clock, reset      : rising-edge clock, async active-low reset
//   m_oe/m_we/m_addr/m_wdata/m_size : packed per-lane requests (held until m_datardy)
//   m_rdata/m_datardy : per-lane registered read data and one-cycle completion
//   s_oe/s_we/s_addr/s_wdata/s_size : memory command, driven only while BUSY
//   s_rdata/s_datardy : memory response
//   clear_err         : synchronous clear of the error flags
//   err_proto/err_timeout/err_lane : sticky error flags and lane of latest error
module mem_channel_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SIZE_W  = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          m_oe,
  input  logic [1:0]          m_we,
  input  logic [2*ADDR_W-1:0] m_addr,
  input  logic [2*DATA_W-1:0] m_wdata,
  input  logic [2*SIZE_W-1:0] m_size,
  output logic [2*DATA_W-1:0] m_rdata,
  output logic [1:0]          m_datardy,
  output logic                s_oe,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [SIZE_W-1:0]   s_size,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_datardy,
  input  logic                clear_err,
  output logic                err_proto,
  output logic                err_timeout,
  output logic                err_lane
);

  localparam int unsigned     CNT_W    = 16;
  localparam int unsigned     MDATA_W  = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0] valid;
  logic [1:0] both;
  logic       grant;
  logic       grant_lane;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_owner_q, last_owner_d;
  logic [MDATA_W-1:0]  m_rdata_q, m_rdata_d;
  logic [1:0]          m_datardy_q, m_datardy_d;
  logic                err_proto_q, err_proto_d;
  logic                err_timeout_q, err_timeout_d;
  logic                err_lane_q, err_lane_d;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      valid[i] = lane_valid(m_oe[i], m_we[i]);
      both[i]  = m_oe[i] & m_we[i];
    end
  end

  rr_pick2 u_pick (
    .valid      (valid),
    .last_owner (last_owner_q),
    .grant      (grant),
    .grant_lane (grant_lane)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    size_d        = size_q;
    cnt_d         = cnt_q;
    last_owner_d  = last_owner_q;
    m_rdata_d     = '0;
    m_datardy_d   = '0;
    err_proto_d   = err_proto_q;
    err_timeout_d = err_timeout_q;
    err_lane_d    = err_lane_q;

    // Clear first so that any error raised in the same cycle overrides it.
    if (clear_err) begin
      err_proto_d   = 1'b0;
      err_timeout_d = 1'b0;
      err_lane_d    = LANE0;
    end
    if (both[0]) begin
      err_proto_d = 1'b1;
      err_lane_d  = LANE0;
    end
    if (both[1]) begin
      err_proto_d = 1'b1;
      err_lane_d  = LANE1;
    end

    case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d = grant_lane;
          op_d    = m_we[grant_lane] ? WR : RD;
          addr_d  = ADDR_W'(m_addr >> lane_lsb(grant_lane, ADDR_W));
          wdata_d = DATA_W'(m_wdata >> lane_lsb(grant_lane, DATA_W));
          size_d  = SIZE_W'(m_size >> lane_lsb(grant_lane, SIZE_W));
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A response in the timeout cycle still counts as a normal completion.
        if (s_datardy) begin
          m_rdata_d            = MDATA_W'(s_rdata) << lane_lsb(owner_q, DATA_W);
          m_datardy_d[owner_q] = 1'b1;
          last_owner_d         = owner_q;
          state_d              = RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          m_datardy_d[owner_q] = 1'b1;
          err_timeout_d        = 1'b1;
          err_lane_d           = owner_q;
          last_owner_d         = owner_q;
          state_d              = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner_q       <= LANE0;
      op_q          <= RD;
      addr_q        <= '0;
      wdata_q       <= '0;
      size_q        <= '0;
      cnt_q         <= '0;
      last_owner_q  <= LANE1;
      m_rdata_q     <= '0;
      m_datardy_q   <= '0;
      err_proto_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_lane_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      size_q        <= size_d;
      cnt_q         <= cnt_d;
      last_owner_q  <= last_owner_d;
      m_rdata_q     <= m_rdata_d;
      m_datardy_q   <= m_datardy_d;
      err_proto_q   <= err_proto_d;
      err_timeout_q <= err_timeout_d;
      err_lane_q    <= err_lane_d;
    end
  end

  logic busy;
  assign busy        = (state_q == BUSY);
  assign s_oe        = busy && (op_q == RD);
  assign s_we        = busy && (op_q == WR);
  assign s_addr      = busy ? addr_q  : '0;
  assign s_wdata     = busy ? wdata_q : '0;
  assign s_size      = busy ? size_q  : '0;
  assign m_rdata     = m_rdata_q;
  assign m_datardy   = m_datardy_q;
  assign err_proto   = err_proto_q;
  assign err_timeout = err_timeout_q;
  assign err_lane    = err_lane_q;

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Self-checking bench for mem_channel_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_channel_arbiter;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 4;
  localparam int unsigned TO = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      m_oe, m_we;
  logic [2*AW-1:0] m_addr;
  logic [2*DW-1:0] m_wdata;
  logic [2*SW-1:0] m_size;
  logic [2*DW-1:0] m_rdata;
  logic [1:0]      m_datardy;
  logic            s_oe, s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_size;
  logic [DW-1:0]   s_rdata;
  logic            s_datardy;
  logic            clear_err;
  logic            err_proto, err_timeout, err_lane;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic        model_last;
  int unsigned grants[$];

  mem_channel_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .m_oe(m_oe), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_size(m_size), .m_rdata(m_rdata), .m_datardy(m_datardy),
    .s_oe(s_oe), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_size(s_size),
    .s_rdata(s_rdata), .s_datardy(s_datardy), .clear_err(clear_err),
    .err_proto(err_proto), .err_timeout(err_timeout), .err_lane(err_lane)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {m_rdata, m_datardy, s_oe, s_we, s_addr, s_wdata, s_size,
            err_proto, err_timeout, err_lane};
  endfunction

  task automatic step(input int unsigned n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_lane(input int lane, input logic oe, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
    m_oe[lane] = oe;
    m_we[lane] = we;
    m_addr[lane*AW +: AW]  = a;
    m_wdata[lane*DW +: DW] = d;
    m_size[lane*SW +: SW]  = s;
  endtask

  task automatic do_reset();
    reset = 1'b0; m_oe = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_size = '0;
    s_rdata = '0; s_datardy = 1'b0; clear_err = 1'b0;
    step(2);
    check("reset_outs", all_outs(), '0);
    reset = 1'b1;
    step();
    model_last = 1'b1;
  endtask

  // Reference model: a grant goes to the only requesting lane, or on
  // contention to the lane not served last; the memory answers after a
  // random delay within the timeout window and the owner sees its data
  // one cycle later.
  task automatic run_engine(input int unsigned n_txn, input bit hold_both,
                            input int unsigned req_pct, input int unsigned max_cyc);
    logic [1:0]    pend = '0;
    logic [1:0]    seen;
    logic [1:0]    fresh;
    int unsigned   done = 0, cyc = 0, phase = 0, k = 0, lat = 0;
    logic          lane = 1'b0;
    logic [DW-1:0] exp_rd = '0;
    logic [20:0]   cmd = '0;
    logic          rwe[2];
    logic [AW-1:0] ra[2];
    logic [DW-1:0] rd[2];
    logic [SW-1:0] rs[2];
    while (done < n_txn && cyc < max_cyc) begin
      step();
      cyc++;
      seen  = pend;
      fresh = '0;
      check("mutex", s_oe & s_we, 0);
      case (phase)
        0: begin
          check("quiet_rdy", {m_datardy, m_rdata}, 0);
          if (s_oe | s_we) begin
            if (seen == 2'b11)      lane = ~model_last;
            else if (seen == 2'b10) lane = 1'b1;
            else                    lane = 1'b0;
            check("spurious_grant", seen != 2'b00, 1);
            cmd = {~rwe[lane], rwe[lane], ra[lane], rd[lane], rs[lane]};
            check("grant_cmd", {s_oe, s_we, s_addr, s_wdata, s_size}, cmd);
            grants.push_back(lane);
            lat   = $urandom_range(0, TO - 1);
            k     = 0;
            phase = 1;
          end
        end
        1: begin
          k++;
          check("cmd_stable", {s_oe, s_we, s_addr, s_wdata, s_size}, cmd);
          check("busy_rdy", {m_datardy, m_rdata}, 0);
        end
        default: begin
          check("done_rdy", m_datardy, 2'b01 << lane);
          check("done_rdata", m_rdata, {8'h00, exp_rd} << (int'(lane) * 8));
          check("release_strobe", {s_oe, s_we}, 0);
          s_datardy   = 1'b0;
          pend[lane]  = 1'b0;
          fresh[lane] = 1'b1;
          m_oe[lane]  = 1'b0;
          m_we[lane]  = 1'b0;
          model_last  = lane;
          done++;
          phase = 0;
        end
      endcase
      if (phase == 1) begin
        if (k == lat) begin
          exp_rd    = DW'($urandom);
          s_rdata   = exp_rd;
          s_datardy = 1'b1;
          phase     = 2;
        end else begin
          s_rdata = DW'($urandom);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && !fresh[i] && (hold_both || $urandom_range(0, 99) < req_pct)) begin
          rwe[i] = 1'($urandom_range(0, 1));
          ra[i]  = AW'($urandom);
          rd[i]  = DW'($urandom);
          rs[i]  = SW'($urandom);
          set_lane(i, ~rwe[i], rwe[i], ra[i], rd[i], rs[i]);
          pend[i] = 1'b1;
        end
      end
    end
    m_oe = '0;
    m_we = '0;
    s_datardy = 1'b0;
    check("engine_done", done, n_txn);
    check("engine_no_err", {err_proto, err_timeout}, 0);
    step(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Single read, response two cycles after s_oe.
    set_lane(0, 1'b1, 1'b0, 7'h05, 8'h00, 4'h1);
    step();
    check("t1_soe", {s_oe, s_we, s_addr}, {1'b1, 1'b0, 7'h05});
    check("t1_wait1", m_datardy, 0);
    step();
    check("t1_wait2", m_datardy, 0);
    step();
    s_rdata = 8'hA5; s_datardy = 1'b1;
    step();
    check("t1_rdy", m_datardy, 2'b01);
    check("t1_rdata", m_rdata, 16'h00A5);
    check("t1_strobe_off", {s_oe, s_we}, 0);
    s_datardy = 1'b0;
    set_lane(0, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0);
    step();
    check("t1_idle", all_outs(), 0);

    // Write on lane 1, ready one cycle after s_we.
    set_lane(1, 1'b0, 1'b1, 7'h10, 8'h3C, 4'h8);
    step();
    check("t3_cmd", {s_oe, s_we, s_addr, s_wdata, s_size}, {1'b0, 1'b1, 7'h10, 8'h3C, 4'h8});
    step();
    check("t3_hold", {s_oe, s_we, s_addr, s_wdata, s_size}, {1'b0, 1'b1, 7'h10, 8'h3C, 4'h8});
    s_rdata = 8'h77; s_datardy = 1'b1;
    step();
    check("t3_rdy", m_datardy, 2'b10);
    check("t3_rdata", m_rdata, 16'h7700);
    check("t3_strobe_off", {s_oe, s_we}, 0);
    s_datardy = 1'b0;
    set_lane(1, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0);
    step();

    // Response in the last allowed cycle: normal completion, no error.
    set_lane(0, 1'b1, 1'b0, 7'h22, 8'h00, 4'h2);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t4_tie_hold", {s_oe, s_we, s_addr}, {1'b1, 1'b0, 7'h22});
      check("t4_tie_wait", m_datardy, 0);
      if (k == 8) begin
        s_rdata = 8'h5A; s_datardy = 1'b1;
      end
    end
    step();
    check("t4_tie_rdy", {m_datardy, m_rdata}, {2'b01, 16'h005A});
    check("t4_tie_noerr", err_timeout, 0);
    s_datardy = 1'b0;
    set_lane(0, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0);
    step();

    // Memory never answers: abort after TIMEOUT busy cycles.
    set_lane(0, 1'b1, 1'b0, 7'h33, 8'h00, 4'h2);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t4_to_hold", {s_oe, s_we, s_addr}, {1'b1, 1'b0, 7'h33});
      check("t4_to_wait", m_datardy, 0);
    end
    step();
    check("t4_to_rdy", {m_datardy, m_rdata}, {2'b01, 16'h0000});
    check("t4_to_err", {err_timeout, err_lane}, 2'b10);
    check("t4_to_strobe", {s_oe, s_we}, 0);
    set_lane(0, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0);
    step();
    check("t4_sticky", err_timeout, 1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("t4_cleared", {err_timeout, err_lane}, 0);

    // Protocol error on lane 1 while lane 0 reads.
    set_lane(1, 1'b1, 1'b1, 7'h44, 8'h99, 4'h1);
    set_lane(0, 1'b1, 1'b0, 7'h06, 8'h00, 4'h1);
    step();
    check("t5_err", {err_proto, err_lane}, 2'b11);
    check("t5_cmd", {s_oe, s_we, s_addr}, {1'b1, 1'b0, 7'h06});
    s_rdata = 8'hC3; s_datardy = 1'b1;
    step();
    check("t5_rdy", {m_datardy, m_rdata}, {2'b01, 16'h00C3});
    s_datardy = 1'b0;
    set_lane(0, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t5_lane1_never", {s_oe, s_we, m_datardy}, 0);
    end
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("t5_set_wins", {err_proto, err_lane}, 2'b11);
    set_lane(1, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("t5_cleared", err_proto, 0);

    // Reset two cycles into a read.
    set_lane(0, 1'b1, 1'b0, 7'h09, 8'h00, 4'h1);
    step();
    check("t6_soe", {s_oe, s_addr}, {1'b1, 7'h09});
    step();
    reset = 1'b0; s_rdata = 8'hEE; s_datardy = 1'b1;
    #1;
    check("t6_async", all_outs(), 0);
    step();
    check("t6_in_reset", all_outs(), 0);
    reset = 1'b1; s_datardy = 1'b0;
    step();
    check("t6_regrant", {s_oe, s_we, s_addr}, {1'b1, 1'b0, 7'h09});
    check("t6_no_stale", m_datardy, 0);
    s_rdata = 8'h12; s_datardy = 1'b1;
    step();
    check("t6_rdy", {m_datardy, m_rdata}, {2'b01, 16'h0012});
    s_datardy = 1'b0;
    set_lane(0, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0);
    step();

    // Contention from reset with both lanes held: strict alternation.
    do_reset();
    grants.delete();
    run_engine(6, 1'b1, 0, 200);
    check("alt_count", grants.size(), 6);
    foreach (grants[i]) check("alternate", grants[i], i % 2);

    // Randomized traffic.
    do_reset();
    grants.delete();
    run_engine(40, 1'b0, 30, 3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
